eb_downsize: RTL and testbench
==============================

# eb_downsize

Width-down converter that sits directly downstream of the 1.5-entry elastic buffer and consumes its output handshake. It accepts one wide word of RATIO slices per transfer and emits it as a sequence of OWIDTH-bit beats, least-significant slice first. A per-word length field allows short words, and i_last marks the final beat. It sustains one output beat per cycle, including back-to-back words with no bubble.

## Interface
- OWIDTH, 8: output beat width in bits.
- RATIO, 4: slices per input word; must be >= 1.
- LWIDTH, max(1, $clog2(RATIO)): width of t_len.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- t_data  input  OWIDTH*RATIO  input word; slice k is t_data[k*OWIDTH +: OWIDTH].
- t_len  input  LWIDTH  number of valid slices minus 1, in the range 0..RATIO-1.
- t_valid  input  1  input word valid.
- t_ready  output  1  block accepts the input word this cycle.
- i_data  output  OWIDTH  current output beat.
- i_last  output  1  current beat is the final slice of its word.
- i_valid  output  1  output beat valid.
- i_ready  input  1  downstream accepts the beat.

## Operation
- State registers:
  - busy (1 bit): holding a word.
  - data_q (OWIDTH*RATIO bits): the held word.
  - len_q (LWIDTH bits): the held word's t_len.
  - cnt (LWIDTH bits): index of the current slice.
- Two states:
  - IDLE (busy=0).
  - SEND (busy=1).
- Output decode:
  - i_valid = busy.
  - i_data = slice cnt of data_q.
  - i_last = busy & (cnt == len_q).
- Ready and handshake terms:
  - out_fire = i_valid & i_ready.
  - t_ready = ~busy | (out_fire & i_last).
  - in_fire = t_valid & t_ready.
- Transitions, in priority order:
  - in_fire: data_q <= t_data, len_q <= t_len, cnt <= 0, busy <= 1. This applies in IDLE and also on the last-beat handshake of a word in SEND.
  - out_fire & ~i_last: cnt <= cnt + 1; busy stays 1.
  - out_fire & i_last & ~in_fire: busy <= 0, cnt <= 0.
  - Otherwise hold all state.
- t_len > RATIO-1 is illegal. In that case the behaviour is undefined but must not hang; implement a saturating compare so that i_last asserts at cnt == RATIO-1.
- RATIO = 1: cnt and len_q are constant 0. Every beat is last, and the block acts as a 1-deep registered pipeline stage with full throughput.
- i_data, i_last and i_valid are decoded directly from registers. There is no combinational path from t_* to i_*.
- t_ready has a combinational path from i_ready. This is permitted because the upstream elastic buffer decodes its i_valid from registers only.

## Timing
- Reset (rst high at a clock edge):
  - busy=0, cnt=0, len_q=0, data_q=0.
  - Outputs from the next cycle on: i_valid=0, i_last=0, i_data=0, t_ready=1.
- Reset mid-word discards the held word and any un-emitted slices. An input word presented in the same cycle as reset is not captured.
- Latency: a word accepted at edge N presents slice 0 on i_data in the cycle after edge N.
- Throughput:
  - A word with len L occupies L+1 output cycles when i_ready is held high.
  - Back-to-back words produce a continuous beat stream with no idle cycle.
- Stall: while i_valid=1 and i_ready=0, i_data, i_last, cnt and data_q hold, and t_ready=0.
- Simultaneous events: on the last-beat handshake with t_valid=1, the old word retires and the new word is captured on the same edge.
- t_valid may assert in IDLE without any i_ready dependence, because t_ready=1 in IDLE.

## Test plan
- Reset, then idle with t_valid=0:
  - i_valid=0, i_data=0, t_ready=1 every cycle.
- Single full word, t_data=0x44332211, t_len=3, i_ready=1:
  - beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, starting 1 cycle after accept;
  - i_last only on 0x44;
  - t_ready=0 during the first three beats.
- Back-to-back words 0xDDCCBBAA (len 3) then 0x00000055 (len 0), t_valid held high:
  - beats AA, BB, CC, DD, 55 with no gap;
  - i_last on DD and 55;
  - second word accepted on the DD handshake edge.
- Backpressure with i_ready pattern 1,0,0,1,1,1 on word 0x04030201:
  - beat 0x02 is held stable for 3 cycles;
  - sequence 01, 02, 03, 04 is delivered with no loss or duplication.
- Reset asserted after beat 0x22 of word 0x44332211:
  - the next cycle shows i_valid=0 and t_ready=1;
  - a following word 0x000000EE (len 0) emits only 0xEE.
- Random t_valid/i_ready (10k cycles, random t_len, RATIO=1 and RATIO=4 builds):
  - scoreboard matches slice order and i_last placement;
  - no beat ever has i_valid=0 while a word remains pending with busy=1.

Source files
------------

// File: rtl/eb_downsize.sv
// Width-down converter: takes one wide word of RATIO slices per transfer and
// emits it LSB slice first as OWIDTH-bit beats, one beat per cycle.
//
// state | meaning
// IDLE  | no word held; t_ready=1, i_valid=0
// SEND  | holding a word; emitting slice cnt_q, i_valid=1
module eb_downsize #(
    parameter int OWIDTH = 8,
    parameter int RATIO  = 4,
    parameter int LWIDTH = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OWIDTH*RATIO-1:0]  t_data,
    input  logic [LWIDTH-1:0]        t_len,
    input  logic                     t_valid,
    output logic                     t_ready,
    output logic [OWIDTH-1:0]        i_data,
    output logic                     i_last,
    output logic                     i_valid,
    input  logic                     i_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [LWIDTH-1:0] LAST_IDX = LWIDTH'(RATIO - 1);

    state_t                    state_q, state_d;
    logic [OWIDTH*RATIO-1:0]   data_q, data_d;
    logic [LWIDTH-1:0]         len_q, len_d;
    logic [LWIDTH-1:0]         cnt_q, cnt_d;
    logic                      busy;
    logic                      cnt_at_end;
    logic                      out_fire;
    logic                      in_fire;

    // Saturate at the top slice so an out-of-range t_len can never run cnt off the word.
    assign busy       = (state_q == SEND);
    assign cnt_at_end = (cnt_q == len_q) || (cnt_q == LAST_IDX);

    assign i_valid  = busy;
    assign i_last   = busy & cnt_at_end;
    assign out_fire = busy & i_ready;
    assign t_ready  = ~busy | (out_fire & cnt_at_end);
    assign in_fire  = t_valid & t_ready;

    always_comb begin
        i_data = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt_q == LWIDTH'(k)) begin
                i_data = data_q[k*OWIDTH +: OWIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        if (in_fire) begin
            state_d = SEND;
            data_d  = t_data;
            len_d   = (RATIO == 1) ? '0 : t_len;
            cnt_d   = '0;
        end else if (out_fire && !cnt_at_end) begin
            cnt_d = cnt_q + LWIDTH'(1);
        end else if (out_fire) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_eb_downsize.sv
// Bench for eb_downsize: table-driven words, directed corner sequences and a
// random phase on RATIO=4 and RATIO=1 instances, all checked by scoreboards.
module tb_eb_downsize;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] t_data;
    logic [1:0]  t_len;
    logic        t_valid, t_ready;
    logic [7:0]  i_data;
    logic        i_last, i_valid, i_ready;

    logic [7:0]  t_data1;
    logic [0:0]  t_len1;
    logic        t_valid1, t_ready1;
    logic [7:0]  i_data1;
    logic        i_last1, i_valid1, i_ready1;

    eb_downsize #(.OWIDTH(8), .RATIO(4)) dut4 (
        .clk(clk), .rst(rst),
        .t_data(t_data), .t_len(t_len), .t_valid(t_valid), .t_ready(t_ready),
        .i_data(i_data), .i_last(i_last), .i_valid(i_valid), .i_ready(i_ready)
    );

    eb_downsize #(.OWIDTH(8), .RATIO(1)) dut1 (
        .clk(clk), .rst(rst),
        .t_data(t_data1), .t_len(t_len1), .t_valid(t_valid1), .t_ready(t_ready1),
        .i_data(i_data1), .i_last(i_last1), .i_valid(i_valid1), .i_ready(i_ready1)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  len;
        logic [31:0] beats;
        int          n;
    } vec_t;

    beat_t q4[$];
    beat_t q1[$];
    beat_t b4, b1;
    int    pend4 = 0, pend1 = 0;
    logic  acc4 = 1'b0, acc1 = 1'b0;
    logic  prev_stall4 = 1'b0, prev_stall1 = 1'b0;
    logic [7:0] prev_d4, prev_d1;
    logic  prev_l4, prev_l1;
    int    n_checks = 0;
    int    n_errors = 0;

    vec_t       vecs[5];
    logic [7:0] b2b_seq[5];
    logic [5:0] bp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for RATIO=4: outstanding beat count drives the expected handshakes.
    always @(negedge clk) begin
        if (rst) begin
            q4.delete();
            pend4       = 0;
            prev_stall4 = 1'b0;
        end else begin
            chk("t_ready4", 32'(t_ready), 32'((pend4 == 0) || (pend4 == 1 && i_ready)));
            chk("valid4", 32'(i_valid), 32'(pend4 > 0));
            if (prev_stall4) begin
                chk("hold_data4", 32'(i_data), 32'(prev_d4));
                chk("hold_last4", 32'(i_last), 32'(prev_l4));
            end
            if (i_valid && i_ready) begin
                if (q4.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_beat4: got beat %0h expected none at %0t", i_data, $time);
                end else begin
                    b4 = q4.pop_front();
                    chk("data4", 32'(i_data), 32'(b4.d));
                    chk("last4", 32'(i_last), 32'(b4.l));
                end
            end
            prev_stall4 = i_valid && !i_ready;
            prev_d4     = i_data;
            prev_l4     = i_last;
            if (i_valid && i_ready) pend4--;
            if (t_valid && t_ready) begin
                pend4 += int'(t_len) + 1;
                acc4 = 1'b1;
            end
        end
    end

    // RATIO=1: every word is exactly one last beat whatever t_len says.
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            pend1       = 0;
            prev_stall1 = 1'b0;
        end else begin
            chk("t_ready1", 32'(t_ready1), 32'((pend1 == 0) || (pend1 == 1 && i_ready1)));
            chk("valid1", 32'(i_valid1), 32'(pend1 > 0));
            if (prev_stall1) begin
                chk("hold_data1", 32'(i_data1), 32'(prev_d1));
                chk("hold_last1", 32'(i_last1), 32'(prev_l1));
            end
            if (i_valid1 && i_ready1) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_beat1: got beat %0h expected none at %0t", i_data1, $time);
                end else begin
                    b1 = q1.pop_front();
                    chk("data1", 32'(i_data1), 32'(b1.d));
                    chk("last1", 32'(i_last1), 32'(b1.l));
                end
            end
            prev_stall1 = i_valid1 && !i_ready1;
            prev_d1     = i_data1;
            prev_l1     = i_last1;
            if (i_valid1 && i_ready1) pend1--;
            if (t_valid1 && t_ready1) begin
                pend1 += 1;
                acc1 = 1'b1;
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic [1:0] l,
                             input logic [31:0] eb, input int n);
        int g;
        for (int k = 0; k < n; k++) begin
            q4.push_back({eb[k*8 +: 8], (k == n - 1)});
        end
        t_data  = d;
        t_len   = l;
        t_valid = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!t_ready && g < 50);
        if (!t_ready) chk("accept_timeout", 32'(t_ready), 32'd1);
        @(posedge clk);
        #1;
        t_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while ((q4.size() != 0 || i_valid) && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk(name, 32'(q4.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h44332211, 2'd3, 32'h44332211, 4};
        vecs[1] = '{32'hA1B2C3D4, 2'd1, 32'h0000C3D4, 2};
        vecs[2] = '{32'h12345678, 2'd0, 32'h00000078, 1};
        vecs[3] = '{32'h00FF00FF, 2'd2, 32'h00FF00FF, 3};
        vecs[4] = '{32'h89ABCDEF, 2'd3, 32'h89ABCDEF, 4};
        b2b_seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55};
        bp      = 6'b111001;

        t_data = '0; t_len = '0; t_valid = 1'b0; i_ready = 1'b1;
        t_data1 = '0; t_len1 = '0; t_valid1 = 1'b0; i_ready1 = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("idle_valid", 32'(i_valid), 32'd0);
            chk("idle_data", 32'(i_data), 32'd0);
            chk("idle_last", 32'(i_last), 32'd0);
            chk("idle_tready", 32'(t_ready), 32'd1);
            chk("idle_data1", 32'(i_data1), 32'd0);
        end
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            send_word(vecs[v].data, vecs[v].len, vecs[v].beats, vecs[v].n);
            @(negedge clk);
            chk("lat_valid", 32'(i_valid), 32'd1);
            chk("lat_data", 32'(i_data), 32'(vecs[v].beats[7:0]));
            wait_idle("vec_drain");
        end

        fork
            begin
                send_word(32'hDDCCBBAA, 2'd3, 32'hDDCCBBAA, 4);
                send_word(32'h00000055, 2'd0, 32'h00000055, 1);
            end
            begin
                int g;
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!i_valid && g < 20);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("b2b_valid", 32'(i_valid), 32'd1);
                    chk("b2b_data", 32'(i_data), 32'(b2b_seq[k]));
                    chk("b2b_last", 32'(i_last), 32'(k >= 3));
                end
            end
        join
        wait_idle("b2b_drain");

        send_word(32'h04030201, 2'd3, 32'h04030201, 4);
        for (int p = 0; p < 6; p++) begin
            i_ready = bp[p];
            @(negedge clk);
            if (p >= 1 && p <= 3) chk("stall_data", 32'(i_data), 32'h02);
            if (p == 1 || p == 2) chk("stall_tready", 32'(t_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        i_ready = 1'b1;
        wait_idle("bp_drain");

        send_word(32'h44332211, 2'd3, 32'h44332211, 4);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1; i_ready = 1'b0;
        t_valid = 1'b1; t_data = 32'hCAFEF00D; t_len = 2'd3;
        @(posedge clk);
        #1;
        rst = 1'b0; t_valid = 1'b0; i_ready = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(i_valid), 32'd0);
        chk("rst_tready", 32'(t_ready), 32'd1);
        chk("rst_last", 32'(i_last), 32'd0);
        @(posedge clk);
        #1;
        send_word(32'h000000EE, 2'd0, 32'h000000EE, 1);
        wait_idle("rst_drain");

        acc4 = 1'b0;
        acc1 = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            if (acc4) begin
                t_valid = 1'b0;
                acc4 = 1'b0;
            end
            if (!t_valid && $urandom_range(0, 3) != 0) begin
                t_data  = $urandom;
                t_len   = 2'($urandom_range(0, 3));
                t_valid = 1'b1;
                for (int k = 0; k <= int'(t_len); k++) begin
                    q4.push_back({t_data[k*8 +: 8], (k == int'(t_len))});
                end
            end
            i_ready = ($urandom_range(0, 3) != 0);
            if (acc1) begin
                t_valid1 = 1'b0;
                acc1 = 1'b0;
            end
            if (!t_valid1 && $urandom_range(0, 3) != 0) begin
                t_data1  = 8'($urandom);
                t_len1   = 1'($urandom_range(0, 1));
                t_valid1 = 1'b1;
                q1.push_back({t_data1, 1'b1});
            end
            i_ready1 = ($urandom_range(0, 3) != 0);
        end

        i_ready  = 1'b1;
        i_ready1 = 1'b1;
        for (int g = 0; g < 100; g++) begin
            @(posedge clk);
            #1;
            if (acc4) begin
                t_valid = 1'b0;
                acc4 = 1'b0;
            end
            if (acc1) begin
                t_valid1 = 1'b0;
                acc1 = 1'b0;
            end
            if (!t_valid && !t_valid1 && q4.size() == 0 && q1.size() == 0
                && !i_valid && !i_valid1) break;
        end
        chk("rand_drain4", 32'(q4.size()), 32'd0);
        chk("rand_drain1", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
